flash_access_arbiter: RTL and testbench
=======================================

// Module: flash_access_arbiter
// PURPOSE
//  Shares the cartridge flash between the MSX slot (priority requester) and the
//  ESP8266 programming engine (req/ack requester). Generates timed flash CE/OE/WE
//  cycles for the ESP side and drives the external address/data mux select.
//  Sits between the slot decode logic and the flash pins.
// PARAMETERS
//  ADDR_W    19  ESP-side flash address width
//  T_SETUP   2   clk50m cycles: address/data valid before strobe
//  T_PULSE   4   clk50m cycles: OE/WE low time
//  T_HOLD    2   clk50m cycles: address/data held after strobe
//  T_GUARD   3   idle cycles of synced msx_sltsl before an ESP cycle may start
// PORTS
//  clk50m       in   1       system clock, 50 MHz
//  rst_n        in   1       reset: asynchronous, active low
//  msx_sltsl    in   1       MSX slot select, active low, asynchronous to clk50m
//  msx_cs1      in   1       MSX 4000h-7FFFh select, active low
//  msx_wr       in   1       MSX write strobe, active low
//  msx_wait_n   out  1       MSX /WAIT, active low (only with OBSONET_WAIT_EN)
//  onet_bt1     in   1       board button; 0 = pressed = flash disabled for MSX
//  esp_req      in   1       ESP access request, level, held until esp_ack
//  esp_we       in   1       1 = write, 0 = read; stable while esp_req
//  esp_addr     in   ADDR_W  ESP flash address; stable while esp_req
//  esp_wdata    in   8       ESP write data; stable while esp_req
//  esp_rdata    out  8       read data, valid with esp_ack on a read
//  esp_ack      out  1       1-cycle pulse: access completed
//  esp_err      out  1       1-cycle pulse: access aborted (no-WAIT build only)
//  flash_din    in   8       flash data bus as seen by the arbiter
//  flash_ce     out  1       flash chip enable, active low
//  flash_oe     out  1       flash output enable, active low
//  flash_wr     out  1       flash write enable, active low
//  mux_esp      out  1       1 = ESP drives flash address/data, 0 = MSX
// BEHAVIOUR
//  - Reset: flash_ce/oe/wr=1, msx_wait_n=1, esp_ack=esp_err=0, esp_rdata=0,
//    mux_esp=0, FSM=IDLE, counters=0. Reset mid-cycle returns all of these at once.
//  - msx_sltsl passes a 2-FF synchronizer -> sel_s (active low).
//  - In IDLE and MSX, flash pins follow the MSX bus combinationally:
//    flash_ce=!onet_bt1|msx_sltsl, flash_oe=msx_cs1, flash_wr=msx_wr.
//  - FSM states: IDLE, MSX, SETUP, STROBE, HOLD, RECOVER.
//    IDLE -> MSX on sel_s=0; MSX -> IDLE on sel_s=1 and guard count resets.
//    IDLE -> SETUP when esp_req=1 and guard count reached T_GUARD (saturating).
//    SETUP (T_SETUP cyc, mux_esp=1, ce=0) -> STROBE (T_PULSE cyc; oe=0 if read,
//    wr=0 if write) -> HOLD (T_HOLD cyc, oe=wr=1, ce=0) -> RECOVER (1 cyc,
//    ce=1, mux_esp=0, esp_ack=1) -> IDLE.
//  - Read data captured from flash_din on the last STROBE cycle.
//  - esp_req must drop the cycle after esp_ack; IDLE ignores esp_req for 1 cycle
//    after RECOVER so a held request never double-issues.
//  - One down-counter (3 bits, loaded with T_x-1 on state entry) times every state.
//  - Same-cycle sel_s=0 and esp start condition: MSX wins.
// CONFIGURATION
//  OBSONET_WAIT_EN defined: sel_s=0 during SETUP/STROBE/HOLD drives msx_wait_n=0
//    until RECOVER completes; ESP cycle always finishes, esp_err tied 0.
//  Undefined: msx_wait_n tied 1; sel_s=0 in SETUP/STROBE/HOLD aborts immediately:
//    ce/oe/wr=1, mux_esp=0, esp_err=1 for 1 cycle, state -> MSX.
// STRUCTURE
//  obsonet_pkg: state enum, default timing constants, ADDR_W default.
//  Sub-module sync_2ff (1-bit 2-flop synchronizer, reset value 1) for msx_sltsl.
// TESTING
//  1 MSX read, onet_bt1=1, msx_sltsl=0, msx_cs1=0 -> flash_ce=0, flash_oe=0, mux_esp=0.
//  2 onet_bt1=0 with msx_sltsl=0 -> flash_ce=1 throughout.
//  3 ESP write addr=0x12345 data=0xA5, MSX idle -> ce low 2+4+2 cycles,
//    wr low exactly 4 cycles, esp_ack 1 cycle after HOLD, exactly one ack.
//  4 ESP read, flash_din=0x3C -> esp_rdata=0x3C with esp_ack, oe low 4 cycles.
//  5 msx_sltsl falls in STROBE: WAIT build -> msx_wait_n=0 until RECOVER, then
//    MSX path; no-WAIT build -> esp_err pulse, wr/oe=1 next cycle, no esp_ack.
//  6 rst_n low in STROBE -> all outputs at reset values asynchronously; no ack.

Source files
------------

// File: rtl/obsonet_pkg.sv
// Shared types and default timing for the cartridge flash arbiter.
// Optional build macro used by the arbiter: OBSONET_WAIT_EN.
package obsonet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MSX     = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  localparam int ADDR_W_DEF  = 19;
  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 4;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_GUARD_DEF = 3;
  localparam int CNT_W       = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single active-low level; resets to the inactive (1) value.
module sync_2ff (
  input  logic clk50m,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/flash_access_arbiter.sv
// Arbitrates cartridge flash between the MSX slot (priority) and the ESP programmer.
// Build option: define OBSONET_WAIT_EN to stall the MSX with /WAIT instead of aborting ESP cycles.
module flash_access_arbiter
  import obsonet_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GUARD = T_GUARD_DEF
) (
  input  logic              clk50m,
  input  logic              rst_n,
  input  logic              msx_sltsl,
  input  logic              msx_cs1,
  input  logic              msx_wr,
  output logic              msx_wait_n,
  input  logic              onet_bt1,
  input  logic              esp_req,
  input  logic              esp_we,
  input  logic [ADDR_W-1:0] esp_addr,
  input  logic [7:0]        esp_wdata,
  output logic [7:0]        esp_rdata,
  output logic              esp_ack,
  output logic              esp_err,
  input  logic [7:0]        flash_din,
  output logic              flash_ce,
  output logic              flash_oe,
  output logic              flash_wr,
  output logic              mux_esp,
  output state_t            dbg_state
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] GUARD_MAX = CNT_W'(T_GUARD);

  // Handshake: esp_req is a level held (with esp_we/addr/wdata stable) until a
  // one-cycle esp_ack or esp_err; it is only consumed in IDLE, never right after RECOVER.

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] guard;
  logic             sel_s;
  logic             block;
  logic             esp_busy;
  logic             abort;
  logic             guard_ok;
  logic             unused_esp_bus;

  // Address and write data reach the flash through the external mux.
  assign unused_esp_bus = ^{esp_addr, esp_wdata};

  sync_2ff u_sync (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .d      (msx_sltsl),
    .q      (sel_s)
  );

  assign dbg_state = state;
  assign esp_busy  = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
  assign guard_ok  = (guard == GUARD_MAX);

`ifdef OBSONET_WAIT_EN
  logic wait_lat;
  assign abort      = 1'b0;
  assign msx_wait_n = !((esp_busy && !sel_s) || wait_lat);
`else
  assign abort      = esp_busy && !sel_s;
  assign msx_wait_n = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt != '0) ? cnt - 1'b1 : cnt;
    flash_ce = !onet_bt1 | msx_sltsl;
    flash_oe = msx_cs1;
    flash_wr = msx_wr;
    mux_esp  = 1'b0;
    esp_ack  = 1'b0;
    esp_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        // A slot access seen in the same cycle as an ESP start takes precedence.
        if (!sel_s) begin
          state_nx = ST_MSX;
        end else if (esp_req && guard_ok && !block) begin
          state_nx = ST_SETUP;
          cnt_nx   = LD_SETUP;
        end
      end
      ST_MSX: begin
        if (sel_s) state_nx = ST_IDLE;
      end
      ST_SETUP: begin
        flash_ce = 1'b0;
        flash_oe = 1'b1;
        flash_wr = 1'b1;
        mux_esp  = 1'b1;
        if (cnt == '0) begin
          state_nx = ST_STROBE;
          cnt_nx   = LD_PULSE;
        end
      end
      ST_STROBE: begin
        flash_ce = 1'b0;
        flash_oe = esp_we;
        flash_wr = !esp_we;
        mux_esp  = 1'b1;
        if (cnt == '0) begin
          state_nx = ST_HOLD;
          cnt_nx   = LD_HOLD;
        end
      end
      ST_HOLD: begin
        flash_ce = 1'b0;
        flash_oe = 1'b1;
        flash_wr = 1'b1;
        mux_esp  = 1'b1;
        if (cnt == '0) state_nx = ST_RECOVER;
      end
      ST_RECOVER: begin
        flash_ce = 1'b1;
        flash_oe = 1'b1;
        flash_wr = 1'b1;
        esp_ack  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (abort) begin
      flash_ce = 1'b1;
      flash_oe = 1'b1;
      flash_wr = 1'b1;
      mux_esp  = 1'b0;
      esp_err  = 1'b1;
      state_nx = ST_MSX;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      guard     <= '0;
      block     <= 1'b0;
      esp_rdata <= 8'h00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      block <= (state == ST_RECOVER);
      if (!sel_s) begin
        guard <= '0;
      end else if (!guard_ok) begin
        guard <= guard + 1'b1;
      end
      if ((state == ST_STROBE) && (cnt == '0) && !esp_we && !abort) begin
        esp_rdata <= flash_din;
      end
    end
  end

`ifdef OBSONET_WAIT_EN
  // /WAIT stays asserted through RECOVER once the slot was selected mid-cycle.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      wait_lat <= 1'b0;
    end else if (state == ST_RECOVER) begin
      wait_lat <= 1'b0;
    end else if (esp_busy && !sel_s) begin
      wait_lat <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_flash_access_arbiter.sv
// Bench for flash_access_arbiter: cycle model of the access timeline, directed cases, random traffic.
module tb_flash_access_arbiter;
  import obsonet_pkg::*;

  localparam int ADDR_W  = 19;
  localparam int T_GUARD = 3;

  logic              clk50m = 1'b0;
  logic              rst_n;
  logic              msx_sltsl, msx_cs1, msx_wr, msx_wait_n, onet_bt1;
  logic              esp_req, esp_we, esp_ack, esp_err;
  logic [ADDR_W-1:0] esp_addr;
  logic [7:0]        esp_wdata, esp_rdata, flash_din;
  logic              flash_ce, flash_oe, flash_wr, mux_esp;
  state_t            dbg_state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit esp_done = 1'b0;
  logic [7:0] exp_q[$];

  flash_access_arbiter dut (
    .clk50m (clk50m), .rst_n (rst_n),
    .msx_sltsl (msx_sltsl), .msx_cs1 (msx_cs1), .msx_wr (msx_wr),
    .msx_wait_n (msx_wait_n), .onet_bt1 (onet_bt1),
    .esp_req (esp_req), .esp_we (esp_we), .esp_addr (esp_addr),
    .esp_wdata (esp_wdata), .esp_rdata (esp_rdata), .esp_ack (esp_ack),
    .esp_err (esp_err), .flash_din (flash_din), .flash_ce (flash_ce),
    .flash_oe (flash_oe), .flash_wr (flash_wr), .mux_esp (mux_esp),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #10 clk50m = ~clk50m;

  initial begin
    #3ms;
    $display("FAIL watchdog expired at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ESP access is a timeline of steps 0..8
  // (0-1 setup, 2-5 strobe, 6-7 hold, 8 recover); -1 idle, -2 slot owns the flash.
  int         m_step = -1;
  int         m_old;
  int         m_guard = 0;
  bit         m_s1 = 1'b1, m_s2 = 1'b1, m_sel;
  bit         m_we = 1'b0, m_block = 1'b0, m_wlat = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  bit         m_wait_build;

  initial begin
`ifdef OBSONET_WAIT_EN
    m_wait_build = 1'b1;
`else
    m_wait_build = 1'b0;
`endif
  end

  always @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      m_step = -1; m_guard = 0; m_s1 = 1'b1; m_s2 = 1'b1;
      m_block = 1'b0; m_wlat = 1'b0; m_rdata = 8'h00;
    end else begin
      m_sel = m_s2;
      m_old = m_step;
      if (m_step == -2) begin
        if (m_sel) m_step = -1;
      end else if (m_step == -1) begin
        if (!m_sel) m_step = -2;
        else if (esp_req && m_guard == T_GUARD && !m_block) begin
          m_step = 0;
          m_we = esp_we;
        end
      end else if (!m_wait_build && !m_sel && m_step <= 7) begin
        m_step = -2;
      end else begin
        if (m_step == 5 && !m_we) m_rdata = flash_din;
        if (!m_sel && m_step <= 7) m_wlat = 1'b1;
        if (m_step == 8) begin
          m_step = -1;
          m_wlat = 1'b0;
        end else begin
          m_step++;
        end
      end
      m_block = (m_old == 8);
      m_guard = m_sel ? ((m_guard < T_GUARD) ? m_guard + 1 : m_guard) : 0;
      m_s2 = m_s1;
      m_s1 = msx_sltsl;
    end
  end

  // Compare process: every falling edge, outputs against the model.
  bit e_ce, e_oe, e_wr, e_mux, e_ack, e_err, e_wait, e_busy;
  always @(negedge clk50m) begin
    if (cmp_en) begin
      e_ce = !onet_bt1 | msx_sltsl; e_oe = msx_cs1; e_wr = msx_wr;
      e_mux = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_wait = 1'b1;
      e_busy = (m_step >= 0) && (m_step <= 7);
      if (m_step >= 0) begin
        e_ce = 1'b0; e_oe = 1'b1; e_wr = 1'b1; e_mux = 1'b1;
        if (m_step >= 2 && m_step <= 5) begin
          e_oe = m_we;
          e_wr = !m_we;
        end
        if (m_step == 8) begin
          e_ce = 1'b1; e_mux = 1'b0; e_ack = 1'b1;
        end
      end
      if (m_wait_build) begin
        e_wait = !((e_busy && !m_s2) || m_wlat);
      end else if (e_busy && !m_s2) begin
        e_ce = 1'b1; e_oe = 1'b1; e_wr = 1'b1; e_mux = 1'b0; e_err = 1'b1;
      end
      chk("cyc_ce", flash_ce, e_ce);
      chk("cyc_oe", flash_oe, e_oe);
      chk("cyc_wr", flash_wr, e_wr);
      chk("cyc_mux", mux_esp, e_mux);
      chk("cyc_ack", esp_ack, e_ack);
      chk("cyc_err", esp_err, e_err);
      chk("cyc_wait", msx_wait_n, e_wait);
      chk("cyc_rdata", esp_rdata, m_rdata);
    end
  end

  // Driver: one ESP access with counts of the pin activity it produced.
  int r_ce_lo, r_wr_lo, r_oe_lo, r_acks, r_errs, r_waits;
  bit r_after_err_ok;
  logic [7:0] r_rd;

  task automatic run_esp(input bit we, input logic [ADDR_W-1:0] a, input logic [7:0] wd,
                         input logic [7:0] din, input bit fall);
    int  n = 0;
    int  post = 0;
    bit  ended = 1'b0, fell = 1'b0, fall_pending = 1'b0, err_prev = 1'b0;
    r_ce_lo = 0; r_wr_lo = 0; r_oe_lo = 0; r_acks = 0; r_errs = 0; r_waits = 0;
    r_after_err_ok = 1'b0; r_rd = 8'h00;
    @(posedge clk50m); #1;
    esp_we = we; esp_addr = a; esp_wdata = wd; flash_din = din; esp_req = 1'b1;
    while (n < 80 && post < 3) begin
      @(negedge clk50m);
      n++;
      if (mux_esp && !flash_ce) r_ce_lo++;
      if (mux_esp && !flash_wr) r_wr_lo++;
      if (mux_esp && !flash_oe) r_oe_lo++;
      if (!msx_wait_n) r_waits++;
      if (esp_ack) begin r_acks++; r_rd = esp_rdata; end
      if (err_prev) r_after_err_ok = flash_wr && flash_oe;
      err_prev = esp_err;
      if (esp_err) r_errs++;
      if (fall && !fell && mux_esp && (!flash_wr || !flash_oe)) begin
        fall_pending = 1'b1;
        fell = 1'b1;
      end
      if (ended) post++;
      if (esp_ack || esp_err) ended = 1'b1;
      @(posedge clk50m); #1;
      if (ended) esp_req = 1'b0;
      if (fall_pending) begin msx_sltsl = 1'b0; fall_pending = 1'b0; end
    end
    esp_req = 1'b0;
  endtask

  initial begin
    int n;
    int got;
    logic [7:0] din;
    bit we;
    rst_n = 1'b0; msx_sltsl = 1'b1; msx_cs1 = 1'b1; msx_wr = 1'b1; onet_bt1 = 1'b1;
    esp_req = 1'b0; esp_we = 1'b0; esp_addr = '0; esp_wdata = 8'h00; flash_din = 8'h00;
    repeat (3) @(posedge clk50m);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // reset state
    @(negedge clk50m);
    chk("rst_ce", flash_ce, 1); chk("rst_oe", flash_oe, 1); chk("rst_wr", flash_wr, 1);
    chk("rst_mux", mux_esp, 0); chk("rst_ack", esp_ack, 0); chk("rst_err", esp_err, 0);
    chk("rst_wait", msx_wait_n, 1); chk("rst_rdata", esp_rdata, 8'h00);

    // MSX read passes straight through
    @(posedge clk50m); #1 msx_sltsl = 1'b0; msx_cs1 = 1'b0;
    @(negedge clk50m);
    chk("msx_ce", flash_ce, 0); chk("msx_oe", flash_oe, 0); chk("msx_mux", mux_esp, 0);

    // button pressed keeps flash deselected for the slot
    @(posedge clk50m); #1 onet_bt1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk50m);
      chk("bt1_ce", flash_ce, 1);
    end
    @(posedge clk50m); #1 onet_bt1 = 1'b1; msx_sltsl = 1'b1; msx_cs1 = 1'b1;
    repeat (6) @(posedge clk50m);
    #1;

    // ESP write
    run_esp(1'b1, 19'h12345, 8'hA5, 8'h00, 1'b0);
    chk("wr_ce_low", r_ce_lo, 8); chk("wr_wr_low", r_wr_lo, 4);
    chk("wr_oe_low", r_oe_lo, 0); chk("wr_acks", r_acks, 1); chk("wr_errs", r_errs, 0);

    // ESP read
    run_esp(1'b0, 19'h00F0F, 8'h00, 8'h3C, 1'b0);
    chk("rd_data", r_rd, 8'h3C); chk("rd_oe_low", r_oe_lo, 4);
    chk("rd_wr_low", r_wr_lo, 0); chk("rd_ce_low", r_ce_lo, 8); chk("rd_acks", r_acks, 1);

    // slot selected during the strobe
    run_esp(1'b1, 19'h00042, 8'h5A, 8'h00, 1'b1);
`ifdef OBSONET_WAIT_EN
    chk("fall_waits", r_waits, 4); chk("fall_acks", r_acks, 1); chk("fall_errs", r_errs, 0);
`else
    chk("fall_errs", r_errs, 1); chk("fall_acks", r_acks, 0);
    chk("fall_pins_idle", r_after_err_ok, 1); chk("fall_waits", r_waits, 0);
`endif
    msx_sltsl = 1'b1;
    repeat (6) @(posedge clk50m);
    #1;

    // asynchronous reset in the middle of a strobe
    esp_we = 1'b0; flash_din = 8'h77; esp_req = 1'b1;
    n = 0;
    while (n < 40 && !(mux_esp && !flash_oe)) begin
      @(negedge clk50m);
      n++;
    end
    chk("rst_mid_reached", mux_esp && !flash_oe, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rstm_ce", flash_ce, 1); chk("rstm_oe", flash_oe, 1); chk("rstm_wr", flash_wr, 1);
    chk("rstm_mux", mux_esp, 0); chk("rstm_ack", esp_ack, 0); chk("rstm_err", esp_err, 0);
    chk("rstm_wait", msx_wait_n, 1); chk("rstm_rdata", esp_rdata, 8'h00);
    got = 0;
    repeat (3) begin
      @(negedge clk50m);
      if (esp_ack) got++;
    end
    chk("rstm_no_ack", got, 0);
    esp_req = 1'b0;
    @(posedge clk50m); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk50m);
    #1;

    // randomized traffic from both sides
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 15)) @(posedge clk50m);
          #1;
          we = 1'($urandom_range(0, 1));
          din = 8'($urandom_range(0, 255));
          esp_we = we; esp_addr = ADDR_W'($urandom); esp_wdata = 8'($urandom);
          flash_din = din; esp_req = 1'b1;
          if (!we) exp_q.push_back(din);
          n = 0; got = 0;
          while (got == 0 && n < 400) begin
            @(negedge clk50m);
            n++;
            if (esp_ack) got = 1;
            else if (esp_err) got = 2;
          end
          chk("rnd_timeout", got != 0, 1);
          if (!we && exp_q.size() > 0) begin
            if (got == 1) chk("rnd_rdata", esp_rdata, exp_q.pop_front());
            else void'(exp_q.pop_front());
          end
          @(posedge clk50m); #1 esp_req = 1'b0;
        end
        esp_done = 1'b1;
      end
      begin
        while (!esp_done) begin
          msx_sltsl = 1'b1; msx_cs1 = 1'b1; msx_wr = 1'b1;
          onet_bt1 = ($urandom_range(0, 7) != 0);
          repeat ($urandom_range(5, 25)) @(posedge clk50m);
          #1;
          msx_sltsl = 1'b0;
          for (int j = $urandom_range(1, 10); j > 0; j--) begin
            msx_cs1 = 1'($urandom_range(0, 1));
            msx_wr = 1'($urandom_range(0, 1));
            @(posedge clk50m); #1;
          end
        end
        msx_sltsl = 1'b1; msx_cs1 = 1'b1; msx_wr = 1'b1;
      end
    join

    repeat (4) @(posedge clk50m);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
